// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit/receive blocks.
//   - arb_state_t : transmit-arbiter FSM states, 3-bit encoding
//   - UART_DATA_W : width of one UART data byte
//   - even_parity : even-parity bit of one byte (XOR of all bits)
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    // The bit that makes the total count of ones, including the parity bit, even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector, one bit per requester
//   ptr    : index of the requester served last
//   winner : one-hot first set bit of req, searching from ptr+1 upward
//            with wrap-around. All zeros when req is zero.
//   index  : binary index of winner. Zero when req is zero.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] index
);

    logic found;
    int   cand;

    // Walk the ring from ptr+1 to ptr (inclusive). The first set bit wins, so
    // the requester at ptr itself is considered last.
    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!found && req[cand]) begin
                found         = 1'b1;
                winner[cand]  = 1'b1;
                index         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one even-parity UART transmitter between NREQ
// byte requesters under round-robin priority.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-requester level request, held until ack
//   req_data     : byte of requester i at [8*i+7:8*i]
//   ack          : one-hot, one-cycle pulse when the frame finishes or aborts
//   grant        : one-hot owner of the transmitter, zero when idle
//   tx_data      : byte to the transmitter, stable from START until WAIT ends
//   tx_parity    : even parity of tx_data
//   tx_start     : one-cycle start pulse to the transmitter
//   tx_done      : transmitter frame-done level (high during the stop bit)
//   busy         : high in any state other than IDLE
//   timeout_err  : sticky flag, set when a frame is aborted by the watchdog
//   clr_err      : clears timeout_err; a simultaneous new abort wins
//
// Handshake: a requester raises req with its byte on req_data and holds both
// until it sees its ack bit. req is only looked at in IDLE, and the byte is
// captured in LOAD, so later changes to either do not affect the frame in
// flight. Exactly one ack pulse is returned per grant, completed or aborted.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [UART_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             ack,
    output logic [NREQ-1:0]             grant,
    output logic [UART_DATA_W-1:0]      tx_data,
    output logic                        tx_parity,
    output logic                        tx_start,
    input  logic                        tx_done,
    output logic                        busy,
    output logic                        timeout_err,
    input  logic                        clr_err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [CNT_W-1:0] wait_cnt;
    logic             done_q;
    logic             done_rise;
    logic             to_hit;

    logic [NREQ-1:0]        pick_winner;
    logic [IDX_W-1:0]       pick_index;
    logic [UART_DATA_W-1:0] sel_byte;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_winner),
        .index  (pick_index)
    );

    assign sel_byte = req_data[int'(grant_idx)*UART_DATA_W +: UART_DATA_W];

    // done_q follows tx_done every cycle, so on the first WAIT cycle it holds
    // the level seen during START: a tx_done that was already high on entry
    // does not count as a completion.
    assign done_rise = tx_done & ~done_q;

    // The counter is cleared in START and advances once per WAIT cycle, so
    // reaching TIMEOUT-1 marks the TIMEOUT-th WAIT cycle.
    assign to_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        ack        = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_START;
            end
            ST_START: begin
                tx_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise || to_hit) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ack        = grant;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= IDX_W'(NREQ - 1);
            wait_cnt  <= '0;
            done_q    <= 1'b0;
            tx_data   <= '0;
            tx_parity <= 1'b0;
        end else begin
            done_q <= tx_done;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant     <= pick_winner;
                        grant_idx <= pick_index;
                    end
                end
                ST_LOAD: begin
                    tx_data   <= sel_byte;
                    tx_parity <= even_parity(sel_byte);
                end
                ST_START: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (!done_rise && !to_hit) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    ptr   <= grant_idx;
                    grant <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // A completion edge in the same cycle as the timeout counts as success.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (state == ST_WAIT && !done_rise && to_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NREQ=4, TIMEOUT=15). The bench plays the
// transmitter: it watches tx_start and drives tx_done. Expected winners come
// from a round-robin model over the request vector; expected latencies come
// from the frame timing (IDLE, LOAD, START, WAIT..., RELEASE).
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_parity;
  logic              tx_start;
  logic              tx_done;
  logic              busy;
  logic              timeout_err;
  logic              clr_err;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_parity   (tx_parity),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // scoreboard state
  int              n_tests = 0;
  int              n_fail  = 0;
  int              last_served;
  logic            err_model;
  logic [NREQ-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first requesting index after the last one served, with wrap.
  function automatic int rr_next(input logic [NREQ-1:0] r, input int from);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(from + i) % NREQ]) return (from + i) % NREQ;
    end
    return -1;
  endfunction

  // One frame, entered at a negedge with the request vector already driven.
  //   delay     : 0 = tx_done never rises (watchdog abort), else cycles after
  //               tx_start (or after the stale level drops) until the rise
  //   stale     : tx_done already high before START, held 2 WAIT cycles
  //   clr_at_to : assert clr_err in the cycle the abort happens
  //   exp_slat  : negedges from entry until tx_start is seen
  //   scramble  : change req/req_data once the frame is under way
  task automatic frame(input int delay, input bit stale, input bit clr_at_to,
                       input int exp_slat, input bit scramble);
    int              w;
    int              s_lat;
    int              lat;
    int              exp_lat;
    logic [7:0]      d;
    logic [NREQ-1:0] got_ack;
    w = rr_next(req, last_served);
    d = req_data[8*w +: 8];
    exp_q.push_back(NREQ'(1) << w);
    if (stale) tx_done = 1'b1;
    s_lat = 0;
    do begin
      @(negedge clk);
      s_lat++;
    end while (tx_start !== 1'b1 && s_lat < 10);
    check_eq("start_latency", s_lat, exp_slat);
    check_eq("grant_onehot", $countones(grant), 1);
    check_eq("grant", grant, NREQ'(1) << w);
    check_eq("tx_data", tx_data, d);
    check_eq("tx_parity", tx_parity, $countones(d) % 2);
    check_eq("busy_in_frame", busy, 1'b1);
    if (scramble) begin
      req      = NREQ'($urandom);
      req_data = $urandom;
    end
    lat     = 0;
    got_ack = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_eq("tx_start_one_cycle", tx_start, 1'b0);
        check_eq("tx_data_held", tx_data, d);
      end
      if (ack !== '0) begin
        got_ack = ack;
        lat     = k;
        break;
      end
      if (delay == 0)  tx_done = 1'b0;
      else if (stale)  tx_done = (k < 3) || (k >= 3 + delay);
      else             tx_done = (k >= delay);
      clr_err = (delay == 0) && clr_at_to && (k == TIMEOUT);
    end
    clr_err = 1'b0;
    tx_done = 1'b0;
    if (delay == 0) begin
      exp_lat   = TIMEOUT + 1;
      err_model = 1'b1;
    end else if (stale) begin
      exp_lat = delay + 4;
    end else begin
      exp_lat = delay + 1;
    end
    check_eq("ack_latency", lat, exp_lat);
    if (exp_q.size() > 0) check_eq("ack", got_ack, exp_q.pop_front());
    check_eq("timeout_err", timeout_err, err_model);
    last_served = w;
  endtask

  initial begin
    rst         = 1'b1;
    req         = '0;
    req_data    = '0;
    tx_done     = 1'b0;
    clr_err     = 1'b0;
    last_served = NREQ - 1;
    err_model   = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_ack", ack, '0);
    check_eq("rst_grant", grant, '0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_tx_parity", tx_parity, 1'b0);
    check_eq("rst_tx_start", tx_start, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_timeout_err", timeout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Round robin with all four requesting: grants 0,1,2,3,0, parity 1 each.
    req_data = {8'h07, 8'h04, 8'h02, 8'h01};
    req      = 4'b1111;
    frame(5, 1'b0, 1'b0, 2, 1'b0);
    for (int i = 1; i <= 4; i++) frame(3 + i, 1'b0, 1'b0, 3, 1'b0);

    // Fairness: serve 1, then with 0 and 1 requesting, 0 wins before 1 again.
    req = 4'b0010;
    frame(2, 1'b0, 1'b0, 3, 1'b0);
    req = 4'b0011;
    frame(2, 1'b0, 1'b0, 3, 1'b0);
    frame(2, 1'b0, 1'b0, 3, 1'b0);

    // Lone requester back to back, fastest completion: 5 cycles between starts.
    req = 4'b0001;
    frame(1, 1'b0, 1'b0, 3, 1'b0);
    frame(1, 1'b0, 1'b0, 3, 1'b0);
    req = '0;
    repeat (2) @(negedge clk);

    // Single request, byte A5 (even number of ones, parity 0).
    req_data[7:0] = 8'hA5;
    req           = 4'b0001;
    frame(12, 1'b0, 1'b0, 2, 1'b0);
    req = '0;
    @(negedge clk);
    check_eq("ack_one_cycle", ack, '0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_grant", grant, '0);

    // Stale tx_done: high through START, completion only on the next rise.
    req_data[23:16] = 8'h3C;
    req             = 4'b0100;
    frame(5, 1'b1, 1'b0, 2, 1'b0);
    req = '0;
    @(negedge clk);

    // Watchdog abort, sticky flag, clear.
    req = 4'b1000;
    frame(0, 1'b0, 1'b0, 2, 1'b0);
    req = '0;
    @(negedge clk);
    check_eq("err_sticky", timeout_err, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err   = 1'b0;
    err_model = 1'b0;
    check_eq("err_cleared", timeout_err, 1'b0);

    // Abort and clear in the same cycle: the set wins.
    req = 4'b0001;
    frame(0, 1'b0, 1'b1, 2, 1'b0);
    req = '0;
    @(negedge clk);
    check_eq("err_set_wins", timeout_err, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err   = 1'b0;
    err_model = 1'b0;
    check_eq("err_cleared2", timeout_err, 1'b0);

    // Randomized frames with mid-frame request/data changes.
    req      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    req_data = $urandom;
    for (int n = 0; n < 40; n++) begin
      bit st;
      int dl;
      st = ($urandom_range(0, 3) == 0);
      dl = st ? $urandom_range(1, 8) : $urandom_range(1, 10);
      frame(dl, st, 1'b0, (n == 0) ? 2 : 3, 1'b1);
      req      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_data = $urandom;
    end

    // Leave the error flag set, then serve requester 0 so the pointer is 0.
    req = 4'b1000;
    frame(0, 1'b0, 1'b0, 3, 1'b0);
    req = 4'b0001;
    frame(3, 1'b0, 1'b0, 3, 1'b0);

    // Reset while requester 1 is in WAIT.
    req = 4'b0010;
    begin
      int s;
      s = 0;
      do begin
        @(negedge clk);
        s++;
      end while (tx_start !== 1'b1 && s < 10);
      check_eq("pre_reset_start", s, 3);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_grant", grant, '0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_tx_start", tx_start, 1'b0);
    check_eq("mid_rst_ack", ack, '0);
    check_eq("mid_rst_err", timeout_err, 1'b0);
    check_eq("mid_rst_tx_data", tx_data, 8'h00);
    @(negedge clk);
    rst         = 1'b0;
    last_served = NREQ - 1;
    err_model   = 1'b0;
    exp_q.delete();
    // With the pointer back at NREQ-1, requester 0 beats requester 2.
    req = 4'b0101;
    frame(3, 1'b0, 1'b0, 2, 1'b0);
    req = '0;
    repeat (2) @(negedge clk);
    check_eq("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
